// File: rtl/eth_gmii_rx_conditioner_if.sv
// PHY-side receive pins and MAC-side conditioned GMII stream with optional frame statistics.
interface eth_gmii_rx_conditioner_if;
  logic [7:0]  phy_rx_d;
  logic        phy_rx_dv;
  logic        phy_rx_er;
  logic [7:0]  gmii_rx_d;
  logic        gmii_rx_dv;
  logic        gmii_rx_err;
  logic [15:0] stat_good_frames;
  logic [15:0] stat_drop_frames;

  modport master (
    output phy_rx_d, phy_rx_dv, phy_rx_er,
    input  gmii_rx_d, gmii_rx_dv, gmii_rx_err, stat_good_frames, stat_drop_frames
  );

  modport slave (
    input  phy_rx_d, phy_rx_dv, phy_rx_er,
    output gmii_rx_d, gmii_rx_dv, gmii_rx_err, stat_good_frames, stat_drop_frames
  );
endinterface

// File: rtl/eth_gmii_rx_conditioner.sv
// GMII RX conditioner: checks preamble/SFD and inter-frame gap, drops malformed frames via a delay line.
// Optional frame counters are enabled with `define ETH_GMII_RX_COND_STATS_EN.
module eth_gmii_rx_conditioner #(
  parameter int PIPE_DEPTH = 10,
  parameter int MIN_PRE    = 1,
  parameter int MIN_IFG    = 12
) (
  input logic                        clk_clk,
  input logic                        reset_reset_n,
  eth_gmii_rx_conditioner_if.slave   bus
);
  localparam int FIFO_D = PIPE_DEPTH / 2 + 1;
  localparam int PW     = $clog2(FIFO_D);
  localparam int CW     = $clog2(FIFO_D + 1);
  localparam int IW     = $clog2(MIN_IFG + 1);

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] d;
  } stage_t;

  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_PRE, S_PASS, S_DROP} state_t;

  // Stage 0 is the input register; stage PIPE_DEPTH-1 feeds the gated output register.
  stage_t [PIPE_DEPTH-1:0] r_pipe;
  state_t                  r_state;
  logic [2:0]              r_pcnt;
  logic [IW-1:0]           r_ifg;
  logic                    r_push, r_push_dec;
  logic [FIFO_D-1:0]       r_fifo;
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_cnt;
  logic                    r_last_dv, r_dec;
  logic                    r_o_dv, r_o_er;
  logic [7:0]              r_o_d;

  logic w_rise, w_empty, w_full, w_unf, w_ovf, w_wr, w_rd, w_head, w_dec, w_odv;
  stage_t w_in;

  assign w_in = '{dv: bus.phy_rx_dv, er: bus.phy_rx_er, d: bus.phy_rx_d};

  // Frames already running when reset released never enter the delay line as valid.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_in;
      for (int i = 1; i < PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      r_pipe[1].dv <= r_pipe[0].dv & (r_state != S_WAIT);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= S_WAIT;
      r_pcnt     <= '0;
      r_ifg      <= IW'(MIN_IFG);
      r_push     <= 1'b0;
      r_push_dec <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_pipe[0].dv)                r_ifg <= '0;
      else if (r_ifg < IW'(MIN_IFG))   r_ifg <= r_ifg + 1'b1;
      case (r_state)
        S_WAIT: if (!r_pipe[0].dv) r_state <= S_IDLE;
        S_IDLE: begin
          if (r_pipe[0].dv) begin
            if (r_ifg >= IW'(MIN_IFG) && r_pipe[0].d == 8'h55) begin
              r_state <= S_PRE;
              r_pcnt  <= 3'd1;
            end else begin
              r_state    <= S_DROP;
              r_push     <= 1'b1;
              r_push_dec <= 1'b0;
            end
          end
        end
        S_PRE: begin
          if (!r_pipe[0].dv) begin
            r_state    <= S_IDLE;
            r_push     <= 1'b1;
            r_push_dec <= 1'b0;
          end else if (!r_pipe[0].er && r_pipe[0].d == 8'h55 && r_pcnt < 3'd7) begin
            r_pcnt <= r_pcnt + 1'b1;
          end else if (!r_pipe[0].er && r_pipe[0].d == 8'hD5 && r_pcnt >= 3'(MIN_PRE)) begin
            r_state    <= S_PASS;
            r_push     <= 1'b1;
            r_push_dec <= 1'b1;
          end else begin
            r_state    <= S_DROP;
            r_push     <= 1'b1;
            r_push_dec <= 1'b0;
          end
        end
        S_PASS, S_DROP: if (!r_pipe[0].dv) r_state <= S_IDLE;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Decision FIFO; an empty FIFO bypasses the decision being pushed this cycle.
  assign w_rise  = r_pipe[PIPE_DEPTH-1].dv & ~r_last_dv;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(FIFO_D));
  assign w_unf   = w_rise & w_empty & ~r_push;
  assign w_ovf   = r_push & w_full & ~w_rise;
  assign w_wr    = r_push & ~w_ovf;
  assign w_rd    = w_rise & ~w_unf;
  assign w_head  = w_empty ? r_push_dec : r_fifo[r_rd];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_fifo <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_fifo[r_wr] <= r_push_dec;
        r_wr         <= (r_wr == PW'(FIFO_D - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_rd) r_rd <= (r_rd == PW'(FIFO_D - 1)) ? '0 : r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_dec = w_rise ? (w_head & ~w_unf) : r_dec;
  assign w_odv = r_pipe[PIPE_DEPTH-1].dv & w_dec;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_last_dv <= 1'b0;
      r_dec     <= 1'b0;
      r_o_dv    <= 1'b0;
      r_o_er    <= 1'b0;
      r_o_d     <= '0;
    end else begin
      r_last_dv <= r_pipe[PIPE_DEPTH-1].dv;
      r_dec     <= w_dec;
      r_o_dv    <= w_odv;
      r_o_er    <= w_odv & r_pipe[PIPE_DEPTH-1].er;
      r_o_d     <= w_odv ? r_pipe[PIPE_DEPTH-1].d : 8'h00;
    end
  end

  assign bus.gmii_rx_dv  = r_o_dv;
  assign bus.gmii_rx_err = r_o_er;
  assign bus.gmii_rx_d   = r_o_d;

`ifdef ETH_GMII_RX_COND_STATS_EN
  logic [15:0] r_good, r_drop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_good <= '0;
      r_drop <= '0;
    end else if (w_rd) begin
      if (w_head && r_good != 16'hFFFF)  r_good <= r_good + 1'b1;
      if (!w_head && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end
  end

  assign bus.stat_good_frames = r_good;
  assign bus.stat_drop_frames = r_drop;
`else
  assign bus.stat_good_frames = 16'h0000;
  assign bus.stat_drop_frames = 16'h0000;
`endif
endmodule
